bdpsk_diff_encoder: RTL and testbench
=====================================

# bdpsk_diff_encoder

- Symbol source for the BDPSK transmit chain.
- Selects one data bit per symbol period and differentially encodes it (re ← re XOR bit).
- Drives the `re` level and the `clk_o` symbol clock into the downstream carrier address controller, which samples `re` on `posedge clk_o` and jumps the 32-entry sine table between 0° and 180° phase.
- Symbol timing comes from a sample counter in the same `clk` domain as the DAC sample clock, so one symbol spans exactly one table period.

## Interface

Parameters:
- `SAMPLES_PER_SYMBOL`, 32: `clk` cycles per symbol; must be even and ≥4; 32 matches one full table sweep.
- `CNT_W`, `$clog2(SAMPLES_PER_SYMBOL)`: width of the sample counter.

Ports:
- `clk` in 1: sample clock, same clock as the DAC; single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `en` in 1: advance symbol timing; when low, all state holds.
- `src_sel` in 1: 0 = external data, 1 = internal PRBS (only with the macro).
- `data_in` in 1: external data bit.
- `data_valid` in 1: `data_in` is valid.
- `data_ready` out 1: block accepts `data_in` this cycle.
- `re` out 1: differentially encoded level to the carrier controller.
- `clk_o` out 1: symbol clock; rising edge at mid-symbol.
- `sym_strobe` out 1: one-cycle pulse at the start of each symbol.
- `bit_out` out 1: raw (pre-encoding) bit of the current symbol, for monitoring.
- `underflow` out 1: sticky flag; external data was missing at a symbol boundary.
- `underflow_clr` in 1: clears `underflow`.

## Operation

- Sample counter `sym_cnt` runs 0..SAMPLES_PER_SYMBOL-1 and wraps to 0. It increments only when `en`=1.
- A boundary edge is a `clk` edge with `en`=1 and `sym_cnt`=SAMPLES_PER_SYMBOL-1. At each boundary edge:
  - choose bit b (rules below);
  - `re` ← `re` ^ b;
  - `bit_out` ← b;
  - `sym_strobe` ← 1.
- `sym_strobe` is low on all other edges.
- Bit selection:
  - External source (`src_sel`=0, or the macro is absent): `data_ready` = `en` & (`sym_cnt`==SAMPLES_PER_SYMBOL-1) & external selected. This is combinational, from registers and inputs.
  - A transfer occurs when `data_valid` & `data_ready`; then b = `data_in`.
  - If `data_valid`=0 at a boundary edge: b = 0, so `re` holds and no phase change is sent. `underflow` ← 1.
  - PRBS source: b = PRBS output bit. `data_ready` = 0 and `data_valid` is ignored.
- `underflow` clears on an edge with `underflow_clr`=1. If a new underflow occurs on the same edge, set wins.
- `clk_o` is a register, high while `sym_cnt` ∈ [SAMPLES_PER_SYMBOL/2, SAMPLES_PER_SYMBOL-1] and low otherwise.
- Reset values:
  - `sym_cnt`=0, `re`=0, `bit_out`=0, `sym_strobe`=0, `clk_o`=0, `underflow`=0;
  - PRBS state = seed 7'h7F;
  - `data_ready`=0 as a consequence.
- Changes to `src_sel` take effect at the next boundary edge and never corrupt the current symbol.

## Timing

- Data latency: an accepted bit appears on `re` and `bit_out` one `clk` after the boundary edge. `sym_strobe` is high in that same cycle, where `sym_cnt`=0.
- `clk_o` rises SAMPLES_PER_SYMBOL/2 cycles after `re` changes, so `re` is stable half a symbol before the downstream controller samples it.
- Symbol period: exactly SAMPLES_PER_SYMBOL `clk` cycles while `en`=1.
- `en` low stretches the period cycle-for-cycle. While `en` is low:
  - `clk_o`, `re` and `bit_out` hold;
  - `sym_strobe` is forced to 0.
- Reset asserted mid-symbol forces all reset values immediately, without waiting for a `clk` edge. The first boundary after release is SAMPLES_PER_SYMBOL cycles after the first `en`=1 edge.
- Throughput: at most one handshake per SAMPLES_PER_SYMBOL cycles.

## Configuration

- `BDPSK_PRBS_EN` defined: the internal PRBS-7 generator is compiled in and `src_sel` is honoured.
  - Polynomial x^7+x^6+1; output bit = `state[6]`.
  - `state` ← {`state[5:0]`, `state[6]`^`state[5]`}.
  - The state advances only on boundary edges where PRBS is selected.
- `BDPSK_PRBS_EN` absent: no PRBS logic. `src_sel` is ignored and external data is always used.

## Structure

- Shared package `bdpsk_pkg` holds:
  - `SAMPLES_PER_SYMBOL_DEF` = 32;
  - `PRBS7_SEED` = 7'h7F;
  - `PRBS7_TAPS` = 7'b1100000;
  - the source-select enum {`SRC_EXT`=0, `SRC_PRBS`=1}.
- One sub-module, `bdpsk_prbs7`, with ports `clk`, `reset_n`, `step`, `bit`. It is instantiated only under `BDPSK_PRBS_EN`.
- All symbol timing and encoding logic stays in the top module.

## Test plan

- **Reset:** assert `reset_n`=0 mid-symbol with `re`=1 → `re`, `clk_o`, `sym_strobe`, `underflow` and `bit_out` read 0 with no `clk` edge required. The first `sym_strobe` comes 32 cycles after release with `en`=1.
- **External handshake:** `src_sel`=0, `data_valid`=1, data 1,1,0,1 → `data_ready` high for exactly 1 cycle per 32. `re` sequence is 1,0,0,1. `clk_o` rises 16 cycles after each `re` change.
- **Underflow:**
  - drop `data_valid` at one boundary → `re` unchanged, `bit_out`=0, `underflow`=1 and held;
  - pulse `underflow_clr` → 0;
  - `underflow_clr` on the same edge as a new underflow → `underflow` stays 1.
- **PRBS** (`BDPSK_PRBS_EN`, `src_sel`=1):
  - first 7 `bit_out` values are 1 and the 8th is 0;
  - `re` reads 1,0,1,0,1,0,1,1;
  - sequence period is 127 symbols;
  - `data_ready` stays 0.
- **Enable stall:** drop `en` for 10 cycles at `sym_cnt`=5 → that symbol lasts 42 cycles, `clk_o`/`re` hold, and no `sym_strobe` appears during the stall.
- **Source switch:** toggle `src_sel` at `sym_cnt`=20 → the current symbol completes and the new source applies at the next boundary only.

Source files
------------

// File: rtl/bdpsk_pkg.sv
// Shared constants, the source-select encoding and the PRBS-7 step function
// for the BDPSK symbol source.
package bdpsk_pkg;

   localparam int         SAMPLES_PER_SYMBOL_DEF = 32;
   localparam logic [6:0] PRBS7_SEED             = 7'h7F;
   localparam logic [6:0] PRBS7_TAPS             = 7'b1100000;

   typedef enum logic {
      SRC_EXT  = 1'b0,
      SRC_PRBS = 1'b1
   } src_sel_e;

   // x^7 + x^6 + 1: feedback is the XOR of the tapped bits, shifted in at the LSB
   function automatic logic [6:0] prbs7_next(input logic [6:0] state);
      return {state[5:0], ^(state & PRBS7_TAPS)};
   endfunction

endpackage

// File: rtl/bdpsk_prbs7.sv
// PRBS-7 generator (x^7+x^6+1). The output is state[6], and the state
// advances only on cycles where step is high.
module bdpsk_prbs7
   import bdpsk_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic step,
   output logic bit_o
);

   logic [6:0] state_q;
   logic [6:0] state_d;

   // next-state: shift only when the encoder consumes a PRBS bit
   always_comb begin
      state_d = state_q;
      if (step) begin
         state_d = prbs7_next(state_q);
      end else begin
         state_d = state_q;
      end
   end

   // state register, reset to the all-ones seed
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= PRBS7_SEED;
      end else begin
         state_q <= state_d;
      end
   end

   assign bit_o = state_q[6];

endmodule

// File: rtl/bdpsk_diff_encoder.sv
// BDPSK symbol source: picks one bit per symbol and differentially encodes it onto re.
// It also produces clk_o and sym_strobe. Define BDPSK_PRBS_EN to compile in the internal PRBS-7 source.
module bdpsk_diff_encoder
   import bdpsk_pkg::*;
#(
   parameter int SAMPLES_PER_SYMBOL = SAMPLES_PER_SYMBOL_DEF,
   parameter int CNT_W              = $clog2(SAMPLES_PER_SYMBOL)
)
(
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   input  logic src_sel,
   input  logic data_in,
   input  logic data_valid,
   output logic data_ready,
   output logic re,
   output logic clk_o,
   output logic sym_strobe,
   output logic bit_out,
   output logic underflow,
   input  logic underflow_clr
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_SYMBOL - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(SAMPLES_PER_SYMBOL / 2);

   logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d, cnt_next_s;
   logic re_q, re_d;
   logic bit_out_q, bit_out_d;
   logic sym_strobe_q, sym_strobe_d;
   logic clk_o_q, clk_o_d;
   logic underflow_q, underflow_d;

   logic boundary_s;
   logic prbs_sel_s;
   logic prbs_bit_s;
   logic sel_bit_s;
   logic miss_s;

   assign boundary_s = en & (sym_cnt_q == CNT_LAST);

`ifdef BDPSK_PRBS_EN
   assign prbs_sel_s = (src_sel_e'(src_sel) == SRC_PRBS);

   bdpsk_prbs7 u_prbs7 (
      .clk     (clk),
      .reset_n (reset_n),
      .step    (boundary_s & prbs_sel_s),
      .bit_o   (prbs_bit_s)
   );
`else
   logic unused_src_sel_s;
   assign unused_src_sel_s = src_sel;
   assign prbs_sel_s       = 1'b0;
   assign prbs_bit_s       = 1'b0;
`endif

   // src_sel is sampled only at the boundary, so a mid-symbol switch cannot disturb the current symbol
   assign data_ready = boundary_s & ~prbs_sel_s;

   // bit selection; a missing external bit sends 0 so the carrier phase holds
   always_comb begin
      sel_bit_s = 1'b0;
      miss_s    = 1'b0;
      if (prbs_sel_s) begin
         sel_bit_s = prbs_bit_s;
      end else if (data_valid) begin
         sel_bit_s = data_in;
      end else begin
         sel_bit_s = 1'b0;
         miss_s    = 1'b1;
      end
   end

   // symbol timing, differential encoding and underflow tracking
   always_comb begin
      cnt_next_s   = (sym_cnt_q == CNT_LAST) ? {CNT_W{1'b0}} : (sym_cnt_q + CNT_W'(1));
      sym_cnt_d    = sym_cnt_q;
      clk_o_d      = clk_o_q;
      re_d         = re_q;
      bit_out_d    = bit_out_q;
      sym_strobe_d = boundary_s;
      underflow_d  = underflow_q;

      if (en) begin
         sym_cnt_d = cnt_next_s;
         clk_o_d   = (cnt_next_s >= CNT_HALF);
      end else begin
         sym_cnt_d = sym_cnt_q;
         clk_o_d   = clk_o_q;
      end

      if (boundary_s) begin
         re_d      = re_q ^ sel_bit_s;
         bit_out_d = sel_bit_s;
      end else begin
         re_d      = re_q;
         bit_out_d = bit_out_q;
      end

      if (boundary_s && miss_s) begin
         underflow_d = 1'b1;
      end else if (underflow_clr) begin
         underflow_d = 1'b0;
      end else begin
         underflow_d = underflow_q;
      end
   end

   // state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sym_cnt_q    <= {CNT_W{1'b0}};
         re_q         <= 1'b0;
         bit_out_q    <= 1'b0;
         sym_strobe_q <= 1'b0;
         clk_o_q      <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         sym_cnt_q    <= sym_cnt_d;
         re_q         <= re_d;
         bit_out_q    <= bit_out_d;
         sym_strobe_q <= sym_strobe_d;
         clk_o_q      <= clk_o_d;
         underflow_q  <= underflow_d;
      end
   end

   assign re         = re_q;
   assign bit_out    = bit_out_q;
   assign sym_strobe = sym_strobe_q;
   assign clk_o      = clk_o_q;
   assign underflow  = underflow_q;

endmodule

// File: tb/tb_bdpsk_diff_encoder.sv
// Directed self-checking bench for bdpsk_diff_encoder. PRBS checks are built
// only when BDPSK_PRBS_EN is defined.
module tb_bdpsk_diff_encoder;

   localparam int SPS = 32;

   logic clk = 1'b0;
   logic reset_n, en, src_sel, data_in, data_valid, underflow_clr;
   logic data_ready, re, clk_o, sym_strobe, bit_out, underflow;

   int   errors = 0;
   int   checks = 0;
   logic m_re;
   int   len, rdy, rise, bad;
   logic re0;

   localparam logic EXT_BITS [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
   localparam logic EXT_RE   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   bdpsk_diff_encoder #(.SAMPLES_PER_SYMBOL(SPS)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .en            (en),
      .src_sel       (src_sel),
      .data_in       (data_in),
      .data_valid    (data_valid),
      .data_ready    (data_ready),
      .re            (re),
      .clk_o         (clk_o),
      .sym_strobe    (sym_strobe),
      .bit_out       (bit_out),
      .underflow     (underflow),
      .underflow_clr (underflow_clr)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // From a negedge, run negedges until the next sym_strobe, returning the
   // symbol length, the data_ready cycle count and the clk_o rise position.
   task automatic run_symbol(input logic d, input logic v,
                             output int o_len, output int o_rdy, output int o_rise);
      data_in    = d;
      data_valid = v;
      o_len = 0; o_rdy = 0; o_rise = 0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (clk_o && o_rise == 0) o_rise = i;
         if (data_ready) o_rdy++;
         if (sym_strobe) begin
            o_len = i;
            break;
         end
      end
   endtask

   task automatic do_sym(input string tag, input logic d, input logic v,
                         input logic exp_b, input int exp_rdy);
      int l, r, ri;
      run_symbol(d, v, l, r, ri);
      check_eq({tag, "_len"}, l, SPS);
      check_eq({tag, "_rdy"}, r, exp_rdy);
      check_eq({tag, "_clko_rise"}, ri, SPS / 2);
      check_eq({tag, "_bit"}, bit_out, exp_b);
      check_eq({tag, "_re"}, re, m_re ^ exp_b);
      m_re = m_re ^ exp_b;
   endtask

   task automatic wait_strobe(input string tag);
      int ok;
      ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (sym_strobe) begin
            ok = 1;
            break;
         end
      end
      check_eq({tag, "_strobe_seen"}, ok, 1);
   endtask

`ifdef BDPSK_PRBS_EN
   localparam logic PRBS_BITS [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   localparam logic PRBS_RE   [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
   logic prbs_seen [134];
`endif

   initial begin
      reset_n = 1'b0; en = 1'b0; src_sel = 1'b0; data_in = 1'b0;
      data_valid = 1'b0; underflow_clr = 1'b0; m_re = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_re", re, 0);
      check_eq("rst_clk_o", clk_o, 0);
      check_eq("rst_strobe", sym_strobe, 0);
      check_eq("rst_bit_out", bit_out, 0);
      check_eq("rst_underflow", underflow, 0);
      check_eq("rst_ready", data_ready, 0);

      // external handshake: data 1,1,0,1 -> re 1,0,0,1
      reset_n = 1'b1; en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         do_sym($sformatf("ext%0d", k), EXT_BITS[k], 1'b1, EXT_BITS[k], 1);
         check_eq($sformatf("ext%0d_re_tbl", k), re, EXT_RE[k]);
      end
      check_eq("ext_no_underflow", underflow, 0);

      // missing data at a boundary, then held, then cleared
      do_sym("uf_miss", 1'b1, 1'b0, 1'b0, 1);
      check_eq("uf_set", underflow, 1);
      do_sym("uf_next", 1'b0, 1'b1, 1'b0, 1);
      check_eq("uf_held", underflow, 1);
      @(negedge clk); underflow_clr = 1'b1;
      @(negedge clk); underflow_clr = 1'b0;
      check_eq("uf_cleared", underflow, 0);

      // clear and new underflow on the same edge: set wins
      data_valid = 1'b0;
      bad = 1;
      for (int i = 0; i < 100; i++) begin
         if (data_ready) begin
            bad = 0;
            break;
         end
         @(negedge clk);
      end
      check_eq("uf_same_ready_seen", bad, 0);
      underflow_clr = 1'b1;
      @(negedge clk);
      underflow_clr = 1'b0;
      check_eq("uf_same_strobe", sym_strobe, 1);
      check_eq("uf_same_set_wins", underflow, 1);
      check_eq("uf_same_re", re, m_re);
      check_eq("uf_same_bit", bit_out, 0);
      data_in = 1'b0; data_valid = 1'b1;
      underflow_clr = 1'b1;
      @(negedge clk);
      underflow_clr = 1'b0;
      check_eq("uf_clr2", underflow, 0);
      wait_strobe("align");

      // enable stall of 10 cycles at sym_cnt=5
      data_in = 1'b1; data_valid = 1'b1;
      re0 = re;
      repeat (5) @(negedge clk);
      en = 1'b0;
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (sym_strobe !== 1'b0 || clk_o !== 1'b0 || re !== re0) bad++;
      end
      check_eq("stall_hold", bad, 0);
      en = 1'b1;
      len = 15;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         len++;
         if (sym_strobe) break;
      end
      check_eq("stall_len", len, 42);
      check_eq("stall_re", re, m_re ^ 1'b1);
      m_re = m_re ^ 1'b1;

      // source switch at sym_cnt=20: current symbol untouched
      data_in = 1'b0; data_valid = 1'b1;
      repeat (20) @(negedge clk);
      src_sel = 1'b1;
      repeat (5) @(negedge clk);
      check_eq("sw_hold_bit", bit_out, 1);
      check_eq("sw_hold_re", re, m_re);
      len = 25; rdy = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         len++;
         if (data_ready) rdy++;
         if (sym_strobe) break;
      end
      check_eq("sw_len", len, SPS);
`ifdef BDPSK_PRBS_EN
      check_eq("sw_rdy", rdy, 0);
      check_eq("sw_bit", bit_out, PRBS_BITS[0]);
      check_eq("sw_re", re, PRBS_RE[0]);
      m_re = re;
      prbs_seen[0] = bit_out;
      for (int k = 1; k < 8; k++) begin
         do_sym($sformatf("prbs%0d", k), 1'b0, 1'b1, PRBS_BITS[k], 0);
         check_eq($sformatf("prbs%0d_re_tbl", k), re, PRBS_RE[k]);
         prbs_seen[k] = bit_out;
      end
      bad = 0;
      for (int k = 8; k < 134; k++) begin
         run_symbol(1'b0, 1'b1, len, rdy, rise);
         if (len != SPS || rdy != 0) bad++;
         prbs_seen[k] = bit_out;
      end
      check_eq("prbs_long_timing", bad, 0);
      bad = 0;
      for (int k = 0; k < 7; k++)
         if (prbs_seen[k + 127] !== prbs_seen[k]) bad++;
      check_eq("prbs_period_127", bad, 0);
      bad = 0;
      for (int s = 1; s < 127; s++) begin
         int same;
         same = 1;
         for (int k = 0; k < 7; k++)
            if (prbs_seen[s + k] !== prbs_seen[k]) same = 0;
         bad += same;
      end
      check_eq("prbs_no_short_period", bad, 0);
      m_re = re;
`else
      check_eq("sw_rdy", rdy, 1);
      check_eq("sw_bit", bit_out, 0);
      check_eq("sw_re", re, m_re);
      check_eq("sw_underflow", underflow, 0);
`endif
      src_sel = 1'b0;

      // asynchronous reset mid-symbol with re=1
      do_sym("pre_rst", ~m_re, 1'b1, ~m_re, 1);
      repeat (10) @(negedge clk);
      check_eq("pre_rst_re", re, 1);
      #1 reset_n = 1'b0;
      #1;
      check_eq("arst_re", re, 0);
      check_eq("arst_clk_o", clk_o, 0);
      check_eq("arst_strobe", sym_strobe, 0);
      check_eq("arst_bit_out", bit_out, 0);
      check_eq("arst_underflow", underflow, 0);
      check_eq("arst_ready", data_ready, 0);
      @(negedge clk);
      reset_n = 1'b1;
      m_re = 1'b0;
      do_sym("post_rst", 1'b1, 1'b1, 1'b1, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
